// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decode-side control bundles and register fields in, and
// stage strobes plus hazard/forwarding controls out, for the 5-stage MIPS
// control pipeline. The master side is the datapath and the slave side is
// ctrl_pipe.
interface ctrl_pipe_if #(
  parameter int REG_W = 5
);
  // Produced by the decode stage and the datapath
  logic [3:0]       id_ex;       // {RegDst, ALUOp1, ALUOp0, ALUSrc}
  logic [2:0]       id_m;        // {Branch, MemRead, MemWrite}
  logic [1:0]       id_wb;       // {RegWrite, MemtoReg}
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             mem_zero;    // ALU zero flag already held in EX/MEM

  // Produced by ctrl_pipe
  logic             ex_regdst;
  logic             ex_alusrc;
  logic [1:0]       ex_aluop;
  logic             mem_branch;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             wb_regwrite;
  logic             wb_memtoreg;
  logic [REG_W-1:0] wb_dest;
  logic             pcsrc;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_ex, id_m, id_wb, id_rs, id_rt, id_rd, mem_zero,
    input  ex_regdst, ex_alusrc, ex_aluop,
           mem_branch, mem_memread, mem_memwrite,
           wb_regwrite, wb_memtoreg, wb_dest,
           pcsrc, pc_write, ifid_write, ifid_flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_ex, id_m, id_wb, id_rs, id_rt, id_rd, mem_zero,
    output ex_regdst, ex_alusrc, ex_aluop,
           mem_branch, mem_memread, mem_memwrite,
           wb_regwrite, wb_memtoreg, wb_dest,
           pcsrc, pc_write, ifid_write, ifid_flush, fwd_a, fwd_b
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the EX/M/WB control bundles through the ID/EX, EX/MEM
// and MEM/WB registers, decodes them into per-stage strobes, and handles the
// load-use stall and the branch flush (BEQ resolves in MEM).
//
// Build option: define CTRL_PIPE_FWD_EN to enable the forwarding unit. In
// that build only load-use hazards stall. Without it, fwd_a/fwd_b are tied
// to 00 and any RAW hazard against ID/EX or EX/MEM stalls until it clears.
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } m_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  // ID/EX
  ex_ctrl_t         idex_ex;
  m_ctrl_t          idex_m;
  wb_ctrl_t         idex_wb;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] idex_rd;
`ifdef CTRL_PIPE_FWD_EN
  logic [REG_W-1:0] idex_rs;   // only the forwarding unit reads rs here
`endif

  // EX/MEM
  m_ctrl_t          exmem_m;
  wb_ctrl_t         exmem_wb;
  logic [REG_W-1:0] exmem_dest;

  // MEM/WB
  wb_ctrl_t         memwb_wb;
  logic [REG_W-1:0] memwb_dest;

  logic [REG_W-1:0] idex_dest;
  logic             take_branch;
  logic             hazard;
  logic             stall;

  // True when a nonzero destination is read by the instruction in ID.
  function automatic logic reads_dest(input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt);
    return (dest != '0) && ((dest == rs) || (dest == rt));
  endfunction

  assign idex_dest   = idex_ex.regdst ? idex_rd : idex_rt;
  assign take_branch = exmem_m.branch & bus.mem_zero;

`ifdef CTRL_PIPE_FWD_EN
  // Forwarding covers ALU results; only a load feeding the next instruction stalls.
  assign hazard = idex_m.memread && reads_dest(idex_rt, bus.id_rs, bus.id_rt);
`else
  // No forwarding: any pending write in ID/EX or EX/MEM to a source register stalls.
  assign hazard = (idex_wb.regwrite  && reads_dest(idex_dest,  bus.id_rs, bus.id_rt)) ||
                  (exmem_wb.regwrite && reads_dest(exmem_dest, bus.id_rs, bus.id_rt));
`endif

  // A taken branch flushes the stalled instruction anyway, so it overrides the stall.
  assign stall = hazard & ~take_branch;

  // Advance the three stage registers, inserting bubbles on stall and flush.
  // NOTE: non-blocking assignments make every register sample the
  // pre-edge value of the stage before it, which is what a pipeline is.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex    <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      idex_rt    <= '0;
      idex_rd    <= '0;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs    <= '0;
`endif
      exmem_m    <= '0;
      exmem_wb   <= '0;
      exmem_dest <= '0;
      memwb_wb   <= '0;
      memwb_dest <= '0;
    end else begin
      idex_rt <= bus.id_rt;
      idex_rd <= bus.id_rd;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs <= bus.id_rs;
`endif
      if (take_branch || stall) begin
        idex_ex <= '0;
        idex_m  <= '0;
        idex_wb <= '0;
      end else begin
        idex_ex <= ex_ctrl_t'(bus.id_ex);
        idex_m  <= m_ctrl_t'(bus.id_m);
        idex_wb <= wb_ctrl_t'(bus.id_wb);
      end

      exmem_dest <= idex_dest;
      if (take_branch) begin
        exmem_m  <= '0;
        exmem_wb <= '0;
      end else begin
        exmem_m  <= idex_m;
        exmem_wb <= idex_wb;
      end

      // The branch itself still retires; its WB bundle is 00.
      memwb_wb   <= exmem_wb;
      memwb_dest <= exmem_dest;
    end
  end

  // Decode stage registers into strobes; everything is forced idle while in reset.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    bus.ex_regdst    = 1'b0;
    bus.ex_aluop     = 2'b00;
    bus.ex_alusrc    = 1'b0;
    bus.mem_branch   = 1'b0;
    bus.mem_memread  = 1'b0;
    bus.mem_memwrite = 1'b0;
    bus.wb_regwrite  = 1'b0;
    bus.wb_memtoreg  = 1'b0;
    bus.wb_dest      = '0;
    bus.pcsrc        = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    if (!rst) begin
      bus.ex_regdst    = idex_ex.regdst;
      bus.ex_aluop     = idex_ex.aluop;
      bus.ex_alusrc    = idex_ex.alusrc;
      bus.mem_branch   = exmem_m.branch;
      bus.mem_memread  = exmem_m.memread;
      bus.mem_memwrite = exmem_m.memwrite;
      bus.wb_regwrite  = memwb_wb.regwrite;
      bus.wb_memtoreg  = memwb_wb.memtoreg;
      bus.wb_dest      = memwb_dest;
      bus.pcsrc        = take_branch;
      bus.ifid_flush   = take_branch;
      bus.pc_write     = ~stall;
      bus.ifid_write   = ~stall;
    end
  end

  // ALU operand selects: EX/MEM result is newer than MEM/WB, so it wins.
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
`ifdef CTRL_PIPE_FWD_EN
    if (!rst) begin
      if (exmem_wb.regwrite && exmem_dest != '0 && exmem_dest == idex_rs)
        bus.fwd_a = 2'b10;
      else if (memwb_wb.regwrite && memwb_dest != '0 && memwb_dest == idex_rs)
        bus.fwd_a = 2'b01;
      if (exmem_wb.regwrite && exmem_dest != '0 && exmem_dest == idex_rt)
        bus.fwd_b = 2'b10;
      else if (memwb_wb.regwrite && memwb_dest != '0 && memwb_dest == idex_rt)
        bus.fwd_b = 2'b01;
    end
`endif
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe. A table of single instructions
// checks decode and stage latency; hand-written sequences cover load-use,
// branch flush, flush-over-stall, forwarding/RAW stall and mid-flight reset.
module tb_ctrl_pipe;

  localparam logic [3:0] R_EX   = 4'b1100;
  localparam logic [1:0] R_WB   = 2'b10;
  localparam logic [3:0] LW_EX  = 4'b0001;
  localparam logic [2:0] LW_M   = 3'b010;
  localparam logic [1:0] LW_WB  = 2'b11;
  localparam logic [3:0] BEQ_EX = 4'b0010;
  localparam logic [2:0] BEQ_M  = 3'b100;

`ifdef CTRL_PIPE_FWD_EN
  localparam int LU_STALLS = 1;
`else
  localparam int LU_STALLS = 2;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ctrl_pipe_if #(.REG_W(5)) bus ();
  ctrl_pipe #(.REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] ex;
    logic [2:0] m;
    logic [1:0] wb;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [3:0] exp_ex;    // {regdst, aluop, alusrc}
    logic [2:0] exp_m;     // {branch, memread, memwrite}
    logic [1:0] exp_wb;    // {regwrite, memtoreg}
    logic [4:0] exp_dest;
  } vec_t;

  vec_t tbl [5];

  logic [3:0] ex_out;
  logic [2:0] mem_out;
  logic [1:0] wb_out;
  assign ex_out  = {bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc};
  assign mem_out = {bus.mem_branch, bus.mem_memread, bus.mem_memwrite};
  assign wb_out  = {bus.wb_regwrite, bus.wb_memtoreg};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.id_ex = ex;
    bus.id_m  = m;
    bus.id_wb = wb;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
  endtask

  task automatic drain();
    set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
    bus.mem_zero = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    //            ex      m       wb     rs    rt    rd     exp_ex  exp_m   exp_wb dest
    tbl[0] = '{R_EX,   3'b000, R_WB,  5'd1, 5'd2, 5'd3,  4'b1100, 3'b000, 2'b10, 5'd3};
    tbl[1] = '{LW_EX,  LW_M,   LW_WB, 5'd1, 5'd4, 5'd9,  4'b0001, 3'b010, 2'b11, 5'd4};
    tbl[2] = '{LW_EX,  3'b001, 2'b00, 5'd2, 5'd6, 5'd11, 4'b0001, 3'b001, 2'b00, 5'd6};
    tbl[3] = '{BEQ_EX, BEQ_M,  2'b00, 5'd1, 5'd2, 5'd12, 4'b0010, 3'b100, 2'b00, 5'd2};
    tbl[4] = '{4'b0,   3'b0,   2'b00, 5'd0, 5'd5, 5'd13, 4'b0000, 3'b000, 2'b00, 5'd5};

    // Reset: held for two edges, outputs idle throughout
    rst = 1'b1;
    set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
    bus.mem_zero = 1'b0;
    #1;
    check("rst_pc_write_pre", {7'b0, bus.pc_write}, 8'd1);
    check("rst_strobes_pre", {ex_out, mem_out, 1'b0}, 8'd0);
    tick();
    check("rst_pc_write", {7'b0, bus.pc_write}, 8'd1);
    check("rst_ifid_write", {7'b0, bus.ifid_write}, 8'd1);
    tick();
    check("rst_strobes", {ex_out, mem_out, wb_out[0]}, 8'd0);
    check("rst_wb", {wb_out, 1'b0, bus.wb_dest}, 8'd0);
    check("rst_hazard_out", {bus.pcsrc, bus.ifid_flush, bus.fwd_a, bus.fwd_b, 2'b0}, 8'd0);
    rst = 1'b0;

    // Table: each instruction alone in the pipe, checked at each stage
    for (int i = 0; i < 5; i++) begin
      set_id(tbl[i].ex, tbl[i].m, tbl[i].wb, tbl[i].rs, tbl[i].rt, tbl[i].rd);
      #1;
      check($sformatf("vec%0d_pc_write", i), {7'b0, bus.pc_write}, 8'd1);
      tick();
      check($sformatf("vec%0d_ex", i), {4'b0, ex_out}, {4'b0, tbl[i].exp_ex});
      set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
      tick();
      check($sformatf("vec%0d_mem", i), {5'b0, mem_out}, {5'b0, tbl[i].exp_m});
      check($sformatf("vec%0d_no_flush", i), {6'b0, bus.pcsrc, bus.ifid_flush}, 8'd0);
      tick();
      check($sformatf("vec%0d_wb", i), {6'b0, wb_out}, {6'b0, tbl[i].exp_wb});
      check($sformatf("vec%0d_dest", i), {3'b0, bus.wb_dest}, {3'b0, tbl[i].exp_dest});
    end
    drain();

    // Load-use: LW rt=5 in ID/EX, R-type in ID reads rs=5
    set_id(LW_EX, LW_M, LW_WB, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd5, 5'd2, 5'd8);
    #1;
    check("lu_pc_write", {7'b0, bus.pc_write}, 8'd0);
    check("lu_ifid_write", {7'b0, bus.ifid_write}, 8'd0);
    tick();
    check("lu_bubble_ex", {4'b0, ex_out}, 8'd0);
    check("lu_load_in_mem", {5'b0, mem_out}, {5'b0, LW_M});
    n = 1;
    while (bus.pc_write !== 1'b1 && n < 4) begin
      n++;
      tick();
    end
    check("lu_stall_cycles", 8'(n), 8'(LU_STALLS));
    tick();
    check("lu_resume_ex", {4'b0, ex_out}, {4'b0, R_EX});
    drain();

    // Load-use against r0 never stalls
    set_id(LW_EX, LW_M, LW_WB, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd0, 5'd0, 5'd8);
    #1;
    check("lu_r0_pc_write", {6'b0, bus.pc_write, bus.ifid_write}, 8'd3);
    tick();
    check("lu_r0_ex", {4'b0, ex_out}, {4'b0, R_EX});
    drain();

    // Branch taken: BEQ in EX/MEM with mem_zero=1
    set_id(BEQ_EX, BEQ_M, 2'b00, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd0, 5'd0, 5'd9);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd0, 5'd0, 5'd10);
    bus.mem_zero = 1'b1;
    #1;
    check("br_pcsrc", {7'b0, bus.pcsrc}, 8'd1);
    check("br_flush", {7'b0, bus.ifid_flush}, 8'd1);
    check("br_no_stall", {6'b0, bus.pc_write, bus.ifid_write}, 8'd3);
    tick();
    bus.mem_zero = 1'b0;
    set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("br_ex_killed", {4'b0, ex_out}, 8'd0);
    check("br_mem_killed", {5'b0, mem_out}, 8'd0);
    check("br_flush_one_cycle", {6'b0, bus.pcsrc, bus.ifid_flush}, 8'd0);
    check("br_wb_beq", {6'b0, wb_out}, 8'd0);
    tick();
    check("br_wb_killed", {6'b0, wb_out}, 8'd0);
    drain();

    // Branch flush coinciding with a load-use match: flush wins
    set_id(BEQ_EX, BEQ_M, 2'b00, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(LW_EX, LW_M, LW_WB, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd5, 5'd2, 5'd8);
    bus.mem_zero = 1'b1;
    #1;
    check("sim_pc_write", {6'b0, bus.pc_write, bus.ifid_write}, 8'd3);
    check("sim_flush", {6'b0, bus.pcsrc, bus.ifid_flush}, 8'd3);
    tick();
    bus.mem_zero = 1'b0;
    set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
    #1;
    check("sim_ex_killed", {4'b0, ex_out}, 8'd0);
    check("sim_mem_killed", {5'b0, mem_out}, 8'd0);
    drain();

    // Back-to-back RAW on r7
    set_id(R_EX, 3'b000, R_WB, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd7, 5'd7, 5'd8);
`ifdef CTRL_PIPE_FWD_EN
    #1;
    check("fwd_no_stall", {7'b0, bus.pc_write}, 8'd1);
    tick();
    check("fwd_exmem", {4'b0, bus.fwd_a, bus.fwd_b}, 8'b0000_1010);
    drain();
    // One instruction in between: value comes from MEM/WB
    set_id(R_EX, 3'b000, R_WB, 5'd1, 5'd2, 5'd7);
    tick();
    set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(R_EX, 3'b000, R_WB, 5'd7, 5'd7, 5'd8);
    tick();
    check("fwd_memwb", {4'b0, bus.fwd_a, bus.fwd_b}, 8'b0000_0101);
`else
    #1;
    n = 0;
    while (bus.pc_write !== 1'b1 && n < 4) begin
      n++;
      tick();
    end
    check("raw_stall_cycles", 8'(n), 8'd2);
    tick();
    check("raw_resume_ex", {4'b0, ex_out}, {4'b0, R_EX});
    check("raw_fwd_zero", {4'b0, bus.fwd_a, bus.fwd_b}, 8'd0);
`endif
    drain();

    // Reset while an R-type with RegWrite sits in EX/MEM
    set_id(R_EX, 3'b000, R_WB, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_pc_write", {7'b0, bus.pc_write}, 8'd1);
    check("mid_rst_wb_gated", {6'b0, wb_out}, 8'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_wb0", {7'b0, bus.wb_regwrite}, 8'd0);
    tick();
    check("mid_rst_wb1", {7'b0, bus.wb_regwrite}, 8'd0);
    tick();
    check("mid_rst_wb2", {7'b0, bus.wb_regwrite}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the EX/M/WB control bundles produced by the decode-stage control unit through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core. It decodes each bundle into individual datapath strobes at the stage that consumes them. It also owns hazard handling: load-use stall with bubble insertion, and branch flush when a BEQ resolves in MEM.

## Interface
Parameters:
- `REG_W`, default 5: register-number width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_ex` in 4: EX bundle {RegDst, ALUOp1, ALUOp0, ALUSrc}.
- `id_m` in 3: M bundle {Branch, MemRead, MemWrite}.
- `id_wb` in 2: WB bundle {RegWrite, MemtoReg}.
- `id_rs`, `id_rt`, `id_rd` in REG_W: register fields of the instruction in ID.
- `mem_zero` in 1: ALU zero flag, already registered in EX/MEM by the datapath.
- `ex_regdst`, `ex_alusrc` out 1; `ex_aluop` out 2: EX-stage strobes.
- `mem_branch`, `mem_memread`, `mem_memwrite` out 1: MEM-stage strobes.
- `wb_regwrite`, `wb_memtoreg` out 1; `wb_dest` out REG_W: WB-stage strobes and destination.
- `pcsrc` out 1: branch taken; PC loads the branch target.
- `pc_write`, `ifid_write` out 1: 0 freezes PC and the IF/ID register.
- `ifid_flush` out 1: zeroes the IF/ID instruction.
- `fwd_a`, `fwd_b` out 2: ALU operand select, 00 regfile, 10 EX/MEM, 01 MEM/WB.

## Operation
- **Stage registers.**
  - ID/EX holds {EX, M, WB, rs, rt, rd}.
  - EX/MEM holds {M, WB, dest}, where dest = RegDst ? rd : rt, taken from ID/EX.
  - MEM/WB holds {WB, dest}.
  - Strobe outputs are direct decodes of the corresponding stage register fields.
- **pcsrc** = EX/MEM.Branch & mem_zero. This is combinational.
- **Load-use hazard** (`lu`): asserted when ID/EX.MemRead=1, ID/EX.rt≠0, and ID/EX.rt equals id_rs or id_rt.
  - Effect: pc_write=0, ifid_write=0, and ID/EX loads all-zero control (bubble). The register fields still load.
- **Branch flush** (pcsrc=1):
  - ifid_flush=1.
  - ID/EX and EX/MEM control are loaded with zero on that edge.
  - MEM/WB loads normally from the branch itself. BEQ's WB is 00, so nothing is written back.
- **Priority:** rst > pcsrc > lu.
  - When pcsrc and lu are both true, the flush wins: pc_write=1, ifid_write=1, no stall.
- **Unrecognised opcodes** arrive as all-zero bundles and propagate as bubbles. No special handling is required.
- Register 0 never triggers a hazard or a forward.

## Timing
- **Latency:** a bundle presented on id_* at edge N appears on ex_* after edge N, on mem_* after edge N+1, and on wb_* after edge N+2.
- The hazard/flush outputs (pc_write, ifid_write, ifid_flush, pcsrc, fwd_*) are combinational from stage registers plus the id_* and mem_zero inputs. They are valid in the same cycle.
- **Reset:**
  - On the rst edge, all stage registers clear.
  - While rst=1, every strobe output, wb_dest, pcsrc, ifid_flush and fwd_* read 0.
  - pc_write and ifid_write read 1.
- **Mid-operation reset:** in-flight bundles are discarded and no writeback occurs afterwards.
- **Stall duration:** a load-use stall lasts exactly one cycle, because the bubble clears ID/EX.MemRead.

## Configuration
- **`CTRL_PIPE_FWD_EN` defined:**
  - Forwarding is active.
  - fwd_a=10 when EX/MEM.RegWrite=1, EX/MEM.dest≠0, and EX/MEM.dest equals ID/EX.rs.
  - Otherwise fwd_a=01 for the same test against MEM/WB. EX/MEM takes precedence.
  - fwd_b is the same against ID/EX.rt.
  - Only load-use hazards stall.
- **`CTRL_PIPE_FWD_EN` undefined:**
  - fwd_a and fwd_b are tied to 00.
  - The stall condition becomes a RAW hazard: id_rs or id_rt (nonzero) matches the dest of an instruction with RegWrite=1 in ID/EX (dest per its RegDst) or in EX/MEM.
  - The stall repeats until the hazard clears, at most 2 cycles.
  - MEM/WB needs no stall because the register file writes in the first half-cycle.

## Test plan
- **Reset then R-type:** rst high 2 cycles, then id_ex=1100, id_m=000, id_wb=10, rd=3.
  - Required: ex_regdst=1, ex_aluop=10 one cycle later; wb_regwrite=1, wb_dest=3 two cycles after that.
  - During rst: pc_write=1 and all strobes 0.
- **Load-use:** LW with rt=5 is in ID/EX; the R-type in ID has rs=5.
  - Required: pc_write=ifid_write=0 for exactly 1 cycle, then ID/EX control=0 (bubble), then resume.
  - With rt=0, no stall occurs.
- **Branch taken:** BEQ reaches EX/MEM with mem_zero=1.
  - Required: pcsrc=1 and ifid_flush=1 for 1 cycle.
  - The next ex_* and mem_* strobes are all 0.
  - With mem_zero=0, pcsrc=0 and no flush.
- **Simultaneous events:** pcsrc=1 in the same cycle as a load-use match.
  - Required: pc_write=1 and ifid_flush=1, with no stall.
- **Forwarding (FWD_EN):** back-to-back R-types; the first writes rd=7, the second reads rs=7 and rt=7.
  - Required: fwd_a=fwd_b=10.
  - With one intervening instruction: fwd_a=fwd_b=01.
  - Without the macro: 2 stall cycles and fwd_*=00.
- **Reset mid-flight:** assert rst while an R-type with RegWrite is in EX/MEM.
  - Required: wb_regwrite stays 0 after the reset edge.
